// File: rtl/alu_host_sequencer_if.sv
// Bundles the request/response handshakes and the ALU control-unit strobes into one interface.
// slave is the sequencer's view; master is the host-plus-ALU side.
interface alu_host_sequencer_if #(
    parameter int WIDTH = 8
);
    logic             req_valid;
    logic             req_ready;
    logic [1:0]       req_op;
    logic [WIDTH-1:0] req_a;
    logic [WIDTH-1:0] req_q;
    logic [WIDTH-1:0] req_m;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_hi;
    logic [WIDTH-1:0] rsp_lo;
    logic             rsp_err;
    logic             alu_begin;
    logic [1:0]       alu_op_code;
    logic [WIDTH-1:0] alu_inbus;
    logic             alu_load_a;
    logic             alu_load_q;
    logic             alu_load_m;
    logic             alu_push_a;
    logic             alu_push_q;
    logic [WIDTH-1:0] alu_outbus;
    logic             alu_end;

    modport slave (
        input  req_valid, req_op, req_a, req_q, req_m, rsp_ready,
        input  alu_load_a, alu_load_q, alu_load_m, alu_push_a, alu_push_q, alu_outbus, alu_end,
        output req_ready, rsp_valid, rsp_hi, rsp_lo, rsp_err,
        output alu_begin, alu_op_code, alu_inbus
    );

    modport master (
        output req_valid, req_op, req_a, req_q, req_m, rsp_ready,
        output alu_load_a, alu_load_q, alu_load_m, alu_push_a, alu_push_q, alu_outbus, alu_end,
        input  req_ready, rsp_valid, rsp_hi, rsp_lo, rsp_err,
        input  alu_begin, alu_op_code, alu_inbus
    );
endinterface

// File: rtl/alu_host_sequencer.sv
// Host-side sequencer: starts the ALU, serves its load strobes, captures pushed results.
// Optional macro ALU_HOST_TIMEOUT_EN adds a BEGIN-to-END watchdog of TIMEOUT_CYCLES.
module alu_host_sequencer #(
    parameter int WIDTH          = 8,
    parameter int TIMEOUT_CYCLES = 256
) (
    input logic                 clk,
    input logic                 reset_input,
    alu_host_sequencer_if.slave bus
);
    typedef enum logic [1:0] {S_IDLE, S_START, S_RUN, S_DONE} state_t;
    localparam logic [1:0] OP_MUL = 2'b10;

    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 2");
    end

    state_t           r_state, w_state_nxt;
    logic [1:0]       r_op;
    logic [WIDTH-1:0] r_a, r_q, r_m;
    logic [WIDTH-1:0] r_cap_a, r_cap_q, r_rsp_hi, r_rsp_lo;
    logic             r_pushed_a, r_pushed_q, r_push_a_p1, r_push_q_p1, r_err;

    logic             w_active, w_accept, w_to_done, w_timeout;
    logic             w_multi_load, w_bad_load, w_dup_push, w_end_err, w_err_now;
    logic             w_req_ready, w_rsp_valid, w_begin;
    logic [1:0]       w_op_code;
    logic [WIDTH-1:0] w_inbus, w_cap_a_nxt, w_cap_q_nxt;

    assign w_active  = (r_state == S_START) || (r_state == S_RUN);
    assign w_accept  = (r_state == S_IDLE) && bus.req_valid;
    assign w_to_done = w_active && (w_state_nxt == S_DONE);

    assign w_multi_load = w_active && ((bus.alu_load_a && bus.alu_load_q) ||
                                       (bus.alu_load_a && bus.alu_load_m) ||
                                       (bus.alu_load_q && bus.alu_load_m));
    assign w_bad_load   = w_active && ((bus.alu_load_q && !r_op[1]) ||
                                       (bus.alu_load_a && (r_op == OP_MUL)));
    assign w_dup_push   = w_active && ((bus.alu_push_a && r_pushed_a) ||
                                       (bus.alu_push_q && r_pushed_q));
    // add/sub expect only an A push; mul and div expect both A and Q
    assign w_end_err    = bus.alu_end && ((r_state == S_START) ||
                          ((r_state == S_RUN) && (!r_pushed_a || (r_op[1] && !r_pushed_q))));
    assign w_err_now    = w_multi_load || w_bad_load || w_dup_push || w_end_err || w_timeout;

    // Delayed push strobe marks the cycle OUTBUS carries the pushed word
    assign w_cap_a_nxt = (w_active && r_push_a_p1) ? bus.alu_outbus : r_cap_a;
    assign w_cap_q_nxt = (w_active && r_push_q_p1) ? bus.alu_outbus : r_cap_q;

`ifdef ALU_HOST_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
    logic [CNT_W-1:0] r_cnt, w_cnt_inc;

    assign w_cnt_inc = r_cnt + CNT_W'(1);
    assign w_timeout = (r_state == S_RUN) && !bus.alu_end &&
                       (w_cnt_inc == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or posedge reset_input) begin
        if (reset_input) begin
            r_cnt <= '0;
        end else if (r_state == S_START) begin
            r_cnt <= '0;
        end else if (r_state == S_RUN) begin
            r_cnt <= w_cnt_inc;
        end
    end
`else
    assign w_timeout = 1'b0;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_req_ready = 1'b0;
        w_rsp_valid = 1'b0;
        w_begin     = 1'b0;
        w_op_code   = 2'b00;
        w_inbus     = '0;
        unique case (r_state)
            S_IDLE: begin
                w_req_ready = 1'b1;
                if (bus.req_valid) w_state_nxt = S_START;
            end
            S_START: begin
                w_begin     = 1'b1;
                w_op_code   = r_op;
                w_state_nxt = bus.alu_end ? S_DONE : S_RUN;
            end
            S_RUN: begin
                w_op_code = r_op;
                if (bus.alu_end || w_timeout) w_state_nxt = S_DONE;
            end
            S_DONE: begin
                w_rsp_valid = 1'b1;
                w_op_code   = r_op;
                if (bus.rsp_ready) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
        if (w_active) begin
            if (bus.alu_load_a)      w_inbus = r_a;
            else if (bus.alu_load_q) w_inbus = r_q;
            else if (bus.alu_load_m) w_inbus = r_m;
        end
    end

    always_ff @(posedge clk or posedge reset_input) begin
        if (reset_input) begin
            r_state     <= S_IDLE;
            r_op        <= 2'b00;
            r_a         <= '0;
            r_q         <= '0;
            r_m         <= '0;
            r_cap_a     <= '0;
            r_cap_q     <= '0;
            r_rsp_hi    <= '0;
            r_rsp_lo    <= '0;
            r_pushed_a  <= 1'b0;
            r_pushed_q  <= 1'b0;
            r_push_a_p1 <= 1'b0;
            r_push_q_p1 <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_op        <= bus.req_op;
                r_a         <= bus.req_a;
                r_q         <= bus.req_q;
                r_m         <= bus.req_m;
                r_cap_a     <= '0;
                r_cap_q     <= '0;
                r_pushed_a  <= 1'b0;
                r_pushed_q  <= 1'b0;
                r_push_a_p1 <= 1'b0;
                r_push_q_p1 <= 1'b0;
                r_err       <= 1'b0;
            end else if (w_active) begin
                r_cap_a     <= w_cap_a_nxt;
                r_cap_q     <= w_cap_q_nxt;
                r_pushed_a  <= r_pushed_a | bus.alu_push_a;
                r_pushed_q  <= r_pushed_q | bus.alu_push_q;
                r_push_a_p1 <= bus.alu_push_a;
                r_push_q_p1 <= bus.alu_push_q;
                if (w_err_now) r_err <= 1'b1;
            end else begin
                r_push_a_p1 <= 1'b0;
                r_push_q_p1 <= 1'b0;
            end
            // Result words use the capture landing on this same edge
            if (w_to_done) begin
                if (w_timeout) begin
                    r_rsp_hi <= '0;
                    r_rsp_lo <= '0;
                end else if (!r_op[1]) begin
                    r_rsp_hi <= '0;
                    r_rsp_lo <= w_cap_a_nxt;
                end else begin
                    r_rsp_hi <= w_cap_a_nxt;
                    r_rsp_lo <= w_cap_q_nxt;
                end
            end
        end
    end

    assign bus.req_ready   = w_req_ready;
    assign bus.rsp_valid   = w_rsp_valid;
    assign bus.rsp_hi      = r_rsp_hi;
    assign bus.rsp_lo      = r_rsp_lo;
    assign bus.rsp_err     = r_err;
    assign bus.alu_begin   = w_begin;
    assign bus.alu_op_code = w_op_code;
    assign bus.alu_inbus   = w_inbus;
endmodule

// File: tb/tb_alu_host_sequencer.sv
// Directed bench for alu_host_sequencer: the bench plays both the host and the ALU control unit.
module tb_alu_host_sequencer;
    localparam int W = 8;

    logic clk = 1'b0;
    logic reset_input = 1'b1;
    int   n_chk = 0;
    int   n_bad = 0;

    alu_host_sequencer_if #(.WIDTH(W)) bus ();

    alu_host_sequencer #(.WIDTH(W), .TIMEOUT_CYCLES(16)) dut (
        .clk         (clk),
        .reset_input (reset_input),
        .bus         (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_alu();
        bus.alu_load_a = 0; bus.alu_load_q = 0; bus.alu_load_m = 0;
        bus.alu_push_a = 0; bus.alu_push_q = 0; bus.alu_end = 0; bus.alu_outbus = '0;
    endtask

    task automatic send_req(input logic [1:0] op, input logic [W-1:0] a, q, m);
        bus.req_valid = 1; bus.req_op = op; bus.req_a = a; bus.req_q = q; bus.req_m = m;
        tick();
        bus.req_valid = 0;
    endtask

    // Full operation up to the first DONE cycle; inject adds a stray load_q cycle
    task automatic do_op(input string tag, input logic [1:0] op, input logic [W-1:0] a, q, m,
                         input logic [W-1:0] va, vq, input bit inject,
                         input logic exp_err, input logic [W-1:0] exp_hi, exp_lo);
        chk({tag, ".req_ready"}, 32'(bus.req_ready), 1);
        send_req(op, a, q, m);
        if (op == 2'b10) bus.alu_load_q = 1; else bus.alu_load_a = 1;
        #1;
        chk({tag, ".begin_start"}, 32'(bus.alu_begin), 1);
        chk({tag, ".inbus_first"}, 32'(bus.alu_inbus), 32'((op == 2'b10) ? q : a));
        chk({tag, ".op_code"}, 32'(bus.alu_op_code), 32'(op));
        tick(); clear_alu();
        if (op == 2'b11) begin
            bus.alu_load_q = 1; #1;
            chk({tag, ".inbus_q"}, 32'(bus.alu_inbus), 32'(q));
            tick(); clear_alu();
        end
        bus.alu_load_m = 1; #1;
        chk({tag, ".begin_run"}, 32'(bus.alu_begin), 0);
        chk({tag, ".inbus_m"}, 32'(bus.alu_inbus), 32'(m));
        tick(); clear_alu();
        if (inject) begin
            bus.alu_load_q = 1; #1;
            chk({tag, ".inbus_inj"}, 32'(bus.alu_inbus), 32'(q));
            tick(); clear_alu();
        end
        if (!op[1]) begin
            bus.alu_push_a = 1; tick(); clear_alu();
            bus.alu_outbus = va; bus.alu_end = 1; tick(); clear_alu();
        end else if (op == 2'b10) begin
            bus.alu_push_a = 1; tick(); clear_alu();
            bus.alu_outbus = va; bus.alu_push_q = 1; tick(); clear_alu();
            bus.alu_outbus = vq; bus.alu_end = 1; tick(); clear_alu();
        end else begin
            bus.alu_push_q = 1; tick(); clear_alu();
            bus.alu_outbus = vq; bus.alu_push_a = 1; tick(); clear_alu();
            bus.alu_outbus = va; bus.alu_end = 1; tick(); clear_alu();
        end
        #1;
        chk({tag, ".rsp_valid"}, 32'(bus.rsp_valid), 1);
        chk({tag, ".req_ready_done"}, 32'(bus.req_ready), 0);
        chk({tag, ".rsp_hi"}, 32'(bus.rsp_hi), 32'(exp_hi));
        chk({tag, ".rsp_lo"}, 32'(bus.rsp_lo), 32'(exp_lo));
        chk({tag, ".rsp_err"}, 32'(bus.rsp_err), 32'(exp_err));
    endtask

    task automatic finish_rsp(input string tag);
        bus.rsp_ready = 1;
        tick();
        bus.rsp_ready = 0;
        #1;
        chk({tag, ".back_idle"}, 32'(bus.req_ready), 1);
        chk({tag, ".valid_low"}, 32'(bus.rsp_valid), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.req_valid = 0; bus.req_op = 0; bus.req_a = 0; bus.req_q = 0; bus.req_m = 0;
        bus.rsp_ready = 0;
        clear_alu();
        tick(); tick();
        chk("rst.req_ready", 32'(bus.req_ready), 1);
        chk("rst.rsp_valid", 32'(bus.rsp_valid), 0);
        chk("rst.rsp_hi", 32'(bus.rsp_hi), 0);
        chk("rst.rsp_lo", 32'(bus.rsp_lo), 0);
        chk("rst.rsp_err", 32'(bus.rsp_err), 0);
        chk("rst.begin", 32'(bus.alu_begin), 0);
        chk("rst.op_code", 32'(bus.alu_op_code), 0);
        chk("rst.inbus", 32'(bus.alu_inbus), 0);
        reset_input = 0;
        tick();

        // Strobes and END in IDLE are ignored
        bus.alu_load_m = 1; bus.alu_end = 1; #1;
        chk("idle.inbus", 32'(bus.alu_inbus), 0);
        tick(); clear_alu(); #1;
        chk("idle.req_ready", 32'(bus.req_ready), 1);
        chk("idle.rsp_valid", 32'(bus.rsp_valid), 0);
        chk("idle.err", 32'(bus.rsp_err), 0);

        do_op("add", 2'b00, 8'd25, 8'd0, 8'd17, 8'd42, 8'd0, 0, 0, 8'h00, 8'h2A);
        finish_rsp("add");
        do_op("mul", 2'b10, 8'd0, 8'h05, 8'h07, 8'h00, 8'h23, 0, 0, 8'h00, 8'h23);
        finish_rsp("mul");
        do_op("div", 2'b11, 8'h00, 8'h64, 8'h07, 8'h02, 8'h0E, 0, 0, 8'h02, 8'h0E);
        finish_rsp("div");
        do_op("sub", 2'b01, 8'd50, 8'd0, 8'd8, 8'd42, 8'd0, 0, 0, 8'h00, 8'h2A);

        // Backpressure: DONE holds until rsp_ready
        for (int i = 0; i < 3; i++) begin
            tick(); #1;
            chk("bp.valid", 32'(bus.rsp_valid), 1);
            chk("bp.lo", 32'(bus.rsp_lo), 32'h2A);
            chk("bp.req_ready", 32'(bus.req_ready), 0);
        end
        finish_rsp("bp");

        do_op("err_loadq", 2'b00, 8'd3, 8'h55, 8'd4, 8'd7, 8'd0, 1, 1, 8'h00, 8'h07);
        finish_rsp("err_loadq");
        do_op("clean_after_err", 2'b00, 8'd1, 8'd0, 8'd2, 8'd3, 8'd0, 0, 0, 8'h00, 8'h03);
        finish_rsp("clean_after_err");

        // Two loads together: A wins on the bus, error flagged
        send_req(2'b00, 8'h11, 8'h22, 8'h33);
        bus.alu_load_a = 1; bus.alu_load_m = 1; #1;
        chk("multi.inbus", 32'(bus.alu_inbus), 32'h11);
        tick(); clear_alu();
        bus.alu_push_a = 1; tick(); clear_alu();
        bus.alu_outbus = 8'h44; bus.alu_end = 1; tick(); clear_alu(); #1;
        chk("multi.valid", 32'(bus.rsp_valid), 1);
        chk("multi.err", 32'(bus.rsp_err), 1);
        chk("multi.lo", 32'(bus.rsp_lo), 32'h44);
        finish_rsp("multi");

        // END with no push at all
        send_req(2'b00, 8'h01, 8'h00, 8'h02);
        bus.alu_load_a = 1; tick(); clear_alu();
        bus.alu_end = 1; tick(); clear_alu(); #1;
        chk("miss.valid", 32'(bus.rsp_valid), 1);
        chk("miss.err", 32'(bus.rsp_err), 1);
        chk("miss.lo", 32'(bus.rsp_lo), 0);
        finish_rsp("miss");

        // Mul with A never pushed twice but Q missing
        send_req(2'b10, 8'h00, 8'h02, 8'h03);
        bus.alu_push_a = 1; tick(); clear_alu();
        bus.alu_outbus = 8'h09; bus.alu_end = 1; tick(); clear_alu(); #1;
        chk("missq.err", 32'(bus.rsp_err), 1);
        chk("missq.hi", 32'(bus.rsp_hi), 32'h09);
        finish_rsp("missq");

        // END during START
        send_req(2'b00, 8'h05, 8'h00, 8'h06);
        bus.alu_end = 1; tick(); clear_alu(); #1;
        chk("endstart.valid", 32'(bus.rsp_valid), 1);
        chk("endstart.err", 32'(bus.rsp_err), 1);
        finish_rsp("endstart");

        // Reset four cycles after BEGIN abandons the operation
        send_req(2'b00, 8'h0A, 8'h00, 8'h0B);
        bus.alu_load_a = 1; tick(); clear_alu();
        tick(); tick(); tick();
        bus.alu_load_a = 1; #1;
        chk("rstrun.inbus_before", 32'(bus.alu_inbus), 32'h0A);
        reset_input = 1; #1;
        chk("rstrun.req_ready", 32'(bus.req_ready), 1);
        chk("rstrun.rsp_valid", 32'(bus.rsp_valid), 0);
        chk("rstrun.begin", 32'(bus.alu_begin), 0);
        chk("rstrun.inbus", 32'(bus.alu_inbus), 0);
        chk("rstrun.op_code", 32'(bus.alu_op_code), 0);
        chk("rstrun.lo", 32'(bus.rsp_lo), 0);
        tick(); clear_alu(); reset_input = 0;
        for (int i = 0; i < 3; i++) begin
            bus.alu_end = (i == 1); tick(); clear_alu(); #1;
            chk("rstrun.no_rsp", 32'(bus.rsp_valid), 0);
        end
        do_op("after_rst", 2'b00, 8'd100, 8'd0, 8'd20, 8'd120, 8'd0, 0, 0, 8'h00, 8'd120);
        finish_rsp("after_rst");

`ifdef ALU_HOST_TIMEOUT_EN
        begin
            int k;
            k = 0;
            send_req(2'b00, 8'h12, 8'h00, 8'h34);
            for (int i = 1; i <= 40 && k == 0; i++) begin
                tick();
                if (bus.rsp_valid) k = i;
            end
            chk("to.cycles", 32'(k), 16);
            chk("to.err", 32'(bus.rsp_err), 1);
            chk("to.hi", 32'(bus.rsp_hi), 0);
            chk("to.lo", 32'(bus.rsp_lo), 0);
            bus.alu_end = 1; tick(); clear_alu(); #1;
            chk("to.late_end", 32'(bus.rsp_valid), 1);
            finish_rsp("to");
        end
`endif

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule

// File: doc/alu_host_sequencer.md
Name: alu_host_sequencer

Overview:
- Host-side counterpart of the ALU control unit. Accepts an operation request through a valid/ready handshake and starts the ALU with BEGIN.
- Serves the ALU's load strobes by driving the matching operand onto INBUS in the same cycle as the strobe.
- Captures OUTBUS after each push strobe and, on END, returns the assembled result through a valid/ready response port.
- Sits between the system/testbench and the ALU datapath plus control unit.

Parameters:
- WIDTH, 8, width of INBUS/OUTBUS and of each operand or result word.
- TIMEOUT_CYCLES, 256, watchdog limit in cycles from BEGIN to END. Used only with ALU_HOST_TIMEOUT_EN.

Ports:
- clk  in  1  clock
- reset_input  in  1  asynchronous reset, active-high
- req_valid  in  1  request valid
- req_ready  out  1  high only in IDLE
- req_op  in  2  00 add, 01 sub, 10 mul, 11 div
- req_a  in  WIDTH  A operand: addend/minuend for add/sub, dividend high word for div
- req_q  in  WIDTH  Q operand: multiplier for mul, dividend low word for div
- req_m  in  WIDTH  M operand: second operand, multiplicand or divisor
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response accepted
- rsp_hi  out  WIDTH  result high word or remainder
- rsp_lo  out  WIDTH  result low word or quotient
- rsp_err  out  1  protocol error or timeout occurred during this operation
- alu_begin  out  1  BEGIN to the control unit
- alu_op_code  out  2  latched op code
- alu_inbus  out  WIDTH  operand bus
- alu_load_a, alu_load_q, alu_load_m  in  1 each  control-unit load strobes
- alu_push_a, alu_push_q  in  1 each  control-unit push strobes
- alu_outbus  in  WIDTH  result bus
- alu_end  in  1  END pulse

Behaviour:
- Reset (asynchronous, active-high):
  - State goes to IDLE. All registers clear.
  - Reset values: req_ready=1, rsp_valid=0, rsp_hi=0, rsp_lo=0, rsp_err=0, alu_begin=0, alu_op_code=00, alu_inbus=0.
  - Reset mid-operation abandons the operation with no response. The ALU shares the same reset line.
- FSM states:
  - IDLE: req_ready=1. On req_valid, latch req_op, req_a, req_q and req_m, clear the capture registers and the error flag, then go to START.
  - START: exactly one cycle with alu_begin=1, then go to RUN.
  - RUN: alu_begin=0. Serve load strobes and capture pushes. On alu_end go to DONE.
  - DONE: rsp_valid=1 and outputs held stable. On rsp_ready go to IDLE. Back-to-back requests therefore have at least one IDLE cycle between them.
- alu_op_code: driven from the latched op in START, RUN and DONE.
- alu_inbus (combinational, zero latency):
  - alu_load_a selects latched A, alu_load_q selects latched Q, alu_load_m selects latched M.
  - With no strobe active, alu_inbus is 0.
  - Strobes are honoured in START as well as RUN, because the control unit raises its first load strobe in the same cycle as BEGIN.
- Capture timing:
  - A push strobe at cycle t means OUTBUS is valid at cycle t+1.
  - The push strobes are registered one cycle. alu_outbus is written into cap_a or cap_q on the delayed strobe.
  - A delayed push and alu_end in the same cycle is the normal case. The capture completes at the same edge as the transition to DONE.
- Result mapping (outputs are registered):
  - add/sub: rsp_lo=cap_a, rsp_hi=0.
  - mul: rsp_hi=cap_a, rsp_lo=cap_q.
  - div: rsp_lo=cap_q (quotient), rsp_hi=cap_a (remainder).
- Protocol errors set rsp_err sticky for the operation; the sequence still continues:
  - More than one load strobe asserted in the same cycle. alu_inbus then takes priority A>Q>M.
  - A load strobe for a register the op does not use: Q for add/sub, A for mul.
  - A second push of the same register.
  - alu_end arriving with the expected pushes missing. Expected pushes: add/sub A only; mul and div A and Q.
- Strobes or alu_end arriving in IDLE or DONE are ignored and are not flagged.
- alu_end arriving in START is treated as a protocol error, and the FSM goes to DONE.

Optional Feature:
- Macro: ALU_HOST_TIMEOUT_EN.
- When defined:
  - A counter clears in START and increments each cycle in RUN.
  - When it reaches TIMEOUT_CYCLES-1 without alu_end: go to DONE with rsp_err=1 and rsp_hi=rsp_lo=0.
  - A late alu_end is then ignored.
- When undefined: there is no counter, and RUN waits indefinitely for alu_end.

Test Plan:
- Add, WIDTH=8. req_op=00, A=25, M=17. The control-unit model strobes load_a, load_m and push_a and drives 42 → rsp_lo=0x2A, rsp_hi=0x00, rsp_err=0. Check that alu_inbus=25 in the same cycle as load_a and 17 with load_m.
- Mul. req_op=10, Q=0x05, M=0x07. The model returns A=0x00, then Q=0x23 → rsp_hi=0x00, rsp_lo=0x23. Check that alu_begin is high for exactly one cycle.
- Div. req_op=11, A=0x00, Q=0x64, M=0x07. The model pushes Q=0x0E, then A=0x02 → rsp_lo=0x0E, rsp_hi=0x02, rsp_err=0.
- Backpressure and error. Hold rsp_ready=0 for 3 cycles → rsp_valid and data stable and req_ready=0. Then inject load_q during an add → rsp_err=1.
- Reset mid-run. Assert reset_input 4 cycles after BEGIN → outputs immediately take reset values, no response is produced, and the next request completes normally.
- Timeout, with ALU_HOST_TIMEOUT_EN and TIMEOUT_CYCLES=16. The model never raises END → rsp_valid rises 16 cycles after START with rsp_err=1 and data=0.
